spike_synapse: RTL and testbench
================================

SPIKE_SYNAPSE -- requirements
Module: spike_synapse

Interface
REQ-001 SHALL have parameter N_IN, default 4: number of presynaptic spike inputs (2..16).
REQ-002 SHALL have parameter TAU_SHIFT, default 4: decay shift; per-cycle decay is current/2^TAU_SHIFT.
REQ-003 SHALL have parameter I_MAX, default 32'sd6553600 (100.0 in Q16.16): symmetric saturation bound on current.
REQ-004 SHALL have parameter W_INIT, default 32'sd655360 (10.0 in Q16.16): reset value of every weight.
REQ-005 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port pre_spike, input, N_IN: level spike flags from presynaptic neurons; high while v >= threshold.
REQ-008 SHALL have port enable, input, 1: high = integrate events and decay; low = hold current.
REQ-009 SHALL have port w_we, input, 1: weight write strobe.
REQ-010 SHALL have port w_addr, input, clog2(N_IN): weight index.
REQ-011 SHALL have port w_data, input, signed 32: weight in Q16.16; negative = inhibitory.
REQ-012 SHALL have port current, output, signed 32: synaptic current in Q16.16 for a neuron current input.
REQ-013 SHALL have port event_cnt, output, 16: count of accepted spike events.
REQ-014 SHALL have port sat, output, 1: high for one cycle when the current update clamped.

Function
REQ-015 SHALL detect an event on input i when pre_spike[i]=1 and its registered previous sample=0; a level held high yields exactly one event.
REQ-016 SHALL update the previous-sample register every cycle regardless of enable.
REQ-017 SHALL, when enable=1, compute next = current - step + sum of weights of all inputs with events this cycle, in at least 40-bit signed arithmetic.
REQ-018 SHALL define step = current >>> TAU_SHIFT (arithmetic); if step=0 and current != 0, step = +1 LSB for positive current and -1 LSB for negative, so current reaches exactly 0.
REQ-019 SHALL clamp next to [-I_MAX, +I_MAX] before registering it, and assert sat for that cycle when clamping occurs.
REQ-020 SHALL register next into current, so an event in cycle k is visible on current in cycle k+1 (latency 1).
REQ-021 SHALL, when enable=0, hold current and event_cnt, drop events, and hold sat at 0.
REQ-022 SHALL add the popcount of this cycle's accepted events to event_cnt, saturating at 0xFFFF with no wrap.
REQ-023 SHALL write w_data to weight[w_addr] at the clock edge when w_we=1; an event on the same index in the same cycle uses the old weight.
REQ-024 SHALL ignore writes with w_addr >= N_IN.

Reset
REQ-025 SHALL, on reset=1, set current=0, event_cnt=0, sat=0, and every weight to W_INIT.
REQ-026 SHALL load the previous-sample register with pre_spike during reset, so a line held high across reset release produces no event.
REQ-027 SHALL let reset take priority over enable, w_we and events, including mid-integration.

Structure
REQ-028 SHALL take FRAC_BITS=16 and the Q16.16 constants (W_INIT, I_MAX defaults) from shared package snn_pkg, used by both neuron and synapse.
REQ-029 SHALL place edge detection in sub-module spike_edge_detect (N_IN wide, with reset-load behaviour of REQ-026).

Verification
REQ-030 SHALL cover: defaults, enable=1, one 0->1 edge on pre_spike[0] -> current=655360 next cycle, then 614400, and 576000 after that.
REQ-031 SHALL cover: pre_spike[1] held high 5 cycles -> exactly one event; event_cnt=1; current rises once, then only decays.
REQ-032 SHALL cover: weight[1]=-262144 (-4.0), simultaneous edges on inputs 0 and 1 from current=0 -> current=393216, event_cnt=2.
REQ-033 SHALL cover: weight[0]=3932160 (60.0), edges in two successive cycles -> 3932160, then clamped to 6553600 with sat=1 for one cycle.
REQ-034 SHALL cover: current=15 LSB, no events -> current decrements 1 LSB per cycle to 0 and stays 0.
REQ-035 SHALL cover: reset mid-decay with pre_spike[2] held high through reset release -> current=0, weights=W_INIT, no event after release.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared fixed-point constants and helpers for the spiking neuron/synapse blocks.
// All currents and weights are signed Q16.16.
package snn_pkg;

    localparam int FRAC_BITS = 16;
    localparam int ACC_W     = 48;

    localparam logic signed [31:0] W_INIT_DEF = 32'sd10 <<< FRAC_BITS;
    localparam logic signed [31:0] I_MAX_DEF  = 32'sd100 <<< FRAC_BITS;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/spike_edge_detect.sv
// Rising-edge detector for level spike flags; the previous sample is
// refreshed every cycle, including during reset, so held lines never re-fire.
module spike_edge_detect #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] din,
    output logic [N-1:0] rise
);

    logic [N-1:0] prev_q;
    logic [N-1:0] prev_d;

    always_comb begin
        prev_d = din;
        rise   = din & ~prev_q & {N{~reset}};
    end

    always_ff @(posedge clk) begin
        prev_q <= prev_d;
    end

endmodule

// File: rtl/spike_synapse.sv
// Weighted synapse: edge-triggered events add per-input weights to a
// leaky, saturating Q16.16 current with one cycle of latency.
module spike_synapse
    import snn_pkg::*;
#(
    parameter int                N_IN      = 4,
    parameter int                TAU_SHIFT = 4,
    parameter logic signed [31:0] I_MAX    = I_MAX_DEF,
    parameter logic signed [31:0] W_INIT   = W_INIT_DEF,
    localparam int               AW        = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_IN-1:0]     pre_spike,
    input  logic                enable,
    input  logic                w_we,
    input  logic [AW-1:0]       w_addr,
    input  logic signed [31:0]  w_data,
    output logic signed [31:0]  current,
    output logic [15:0]         event_cnt,
    output logic                sat
);

    logic [N_IN-1:0]    rise;
    logic [N_IN-1:0]    ev;

    logic signed [31:0] current_q, current_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic signed [31:0] w_q [N_IN];
    logic signed [31:0] w_d [N_IN];

    logic signed [ACC_W-1:0] cur_ext;
    logic signed [ACC_W-1:0] step;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] nxt;
    logic signed [ACC_W-1:0] lim_hi;
    logic signed [ACC_W-1:0] lim_lo;
    logic [16:0]             cnt_sum;

    spike_edge_detect #(
        .N(N_IN)
    ) u_edge (
        .clk  (clk),
        .reset(reset),
        .din  (pre_spike),
        .rise (rise)
    );

    always_comb begin
        ev      = rise & {N_IN{enable}};
        cur_ext = ACC_W'(current_q);
        lim_hi  = ACC_W'(I_MAX);
        lim_lo  = -lim_hi;

        sum = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (ev[i]) begin
                sum = sum + ACC_W'(w_q[i]);
            end
        end

        // Minimum one-LSB leak so small currents still settle to exactly zero.
        step = cur_ext >>> TAU_SHIFT;
        if (step == '0 && cur_ext != '0) begin
            step = (cur_ext > 0) ? ACC_W'(1) : -ACC_W'(1);
        end

        nxt   = cur_ext - step + sum;
        sat_d = 1'b0;
        if (nxt > lim_hi) begin
            nxt   = lim_hi;
            sat_d = enable;
        end else if (nxt < lim_lo) begin
            nxt   = lim_lo;
            sat_d = enable;
        end

        current_d = enable ? 32'(nxt) : current_q;

        cnt_sum = {1'b0, cnt_q} + 17'(popcount16(16'(ev)));
        cnt_d   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

        for (int i = 0; i < N_IN; i++) begin
            w_d[i] = w_q[i];
        end
        if (w_we && (32'(w_addr) < N_IN)) begin
            w_d[w_addr] = w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            current_q <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            for (int i = 0; i < N_IN; i++) begin
                w_q[i] <= W_INIT;
            end
        end else begin
            current_q <= current_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            for (int i = 0; i < N_IN; i++) begin
                w_q[i] <= w_d[i];
            end
        end
    end

    assign current   = current_q;
    assign event_cnt = cnt_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_spike_synapse.sv
// Directed vector bench for spike_synapse with default parameters.
module tb_spike_synapse;

    logic               clk;
    logic               reset;
    logic [3:0]         pre_spike;
    logic               enable;
    logic               w_we;
    logic [1:0]         w_addr;
    logic signed [31:0] w_data;
    logic signed [31:0] current;
    logic [15:0]        event_cnt;
    logic               sat;

    int total;
    int bad;

    typedef struct {
        logic               rst;
        logic               en;
        logic [3:0]         pre;
        logic               we;
        logic [1:0]         addr;
        logic signed [31:0] wd;
        logic signed [31:0] cur;
        logic [15:0]        cnt;
        logic               sat;
    } vec_t;

    vec_t vecs[$];

    spike_synapse dut (
        .clk      (clk),
        .reset    (reset),
        .pre_spike(pre_spike),
        .enable   (enable),
        .w_we     (w_we),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .current  (current),
        .event_cnt(event_cnt),
        .sat      (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic rst, logic en, logic [3:0] pre,
                                logic we, logic [1:0] addr,
                                logic signed [31:0] wd,
                                logic signed [31:0] cur,
                                logic [15:0] cnt, logic s);
        vec_t v;
        v.rst = rst; v.en = en; v.pre = pre; v.we = we;
        v.addr = addr; v.wd = wd; v.cur = cur; v.cnt = cnt; v.sat = s;
        return v;
    endfunction

    task automatic drive(logic rst, logic en, logic [3:0] pre,
                         logic we, logic [1:0] addr, logic signed [31:0] wd);
        reset = rst; enable = en; pre_spike = pre;
        w_we = we; w_addr = addr; w_data = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cur(string nm, logic signed [31:0] exp);
        total++;
        if (current !== exp) begin
            bad++;
            $display("FAIL %s current got=%0d want=%0d", nm, current, exp);
        end
    endtask

    task automatic chk_cnt(string nm, logic [15:0] exp);
        total++;
        if (event_cnt !== exp) begin
            bad++;
            $display("FAIL %s event_cnt got=%0d want=%0d", nm, event_cnt, exp);
        end
    endtask

    task automatic chk_sat(string nm, logic exp);
        total++;
        if (sat !== exp) begin
            bad++;
            $display("FAIL %s sat got=%0b want=%0b", nm, sat, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1; enable = 1'b0; pre_spike = '0;
        w_we = 1'b0; w_addr = '0; w_data = '0;

        // basic event then decay
        vecs.push_back(mk(1, 0, 4'b0000, 0, 0, 0,        0, 0, 0));
        vecs.push_back(mk(0, 1, 4'b0001, 0, 0, 0,   655360, 1, 0));
        vecs.push_back(mk(0, 1, 4'b0001, 0, 0, 0,   614400, 1, 0));
        vecs.push_back(mk(0, 1, 4'b0000, 0, 0, 0,   576000, 1, 0));
        // held level gives one event
        vecs.push_back(mk(1, 1, 4'b0000, 0, 0, 0,        0, 0, 0));
        vecs.push_back(mk(0, 1, 4'b0010, 0, 0, 0,   655360, 1, 0));
        vecs.push_back(mk(0, 1, 4'b0010, 0, 0, 0,   614400, 1, 0));
        vecs.push_back(mk(0, 1, 4'b0010, 0, 0, 0,   576000, 1, 0));
        vecs.push_back(mk(0, 1, 4'b0010, 0, 0, 0,   540000, 1, 0));
        vecs.push_back(mk(0, 1, 4'b0010, 0, 0, 0,   506250, 1, 0));
        vecs.push_back(mk(0, 1, 4'b0000, 0, 0, 0,   474610, 1, 0));
        // inhibitory weight, simultaneous events, enable low hold
        vecs.push_back(mk(1, 0, 4'b0000, 0, 0, 0,        0, 0, 0));
        vecs.push_back(mk(0, 0, 4'b0000, 1, 1, -262144,  0, 0, 0));
        vecs.push_back(mk(0, 1, 4'b0011, 0, 0, 0,   393216, 2, 0));
        vecs.push_back(mk(0, 0, 4'b0000, 0, 0, 0,   393216, 2, 0));
        vecs.push_back(mk(0, 0, 4'b0001, 0, 0, 0,   393216, 2, 0));
        vecs.push_back(mk(0, 1, 4'b0001, 0, 0, 0,   368640, 2, 0));
        // positive saturation
        vecs.push_back(mk(1, 0, 4'b0000, 0, 0, 0,        0, 0, 0));
        vecs.push_back(mk(0, 0, 4'b0000, 1, 0, 3932160,  0, 0, 0));
        vecs.push_back(mk(0, 1, 4'b0001, 0, 0, 0,  3932160, 1, 0));
        vecs.push_back(mk(0, 1, 4'b0000, 0, 0, 0,  3686400, 1, 0));
        vecs.push_back(mk(0, 1, 4'b0001, 0, 0, 0,  6553600, 2, 1));
        vecs.push_back(mk(0, 1, 4'b0001, 0, 0, 0,  6144000, 2, 0));
        // write and event on same index use the old weight
        vecs.push_back(mk(0, 1, 4'b0000, 1, 0, 655360, 5760000, 2, 0));
        vecs.push_back(mk(0, 1, 4'b0001, 1, 0, 0,  6055360, 3, 0));
        vecs.push_back(mk(0, 1, 4'b0000, 0, 0, 0,  5676900, 3, 0));
        vecs.push_back(mk(0, 1, 4'b0001, 0, 0, 0,  5322094, 4, 0));
        // negative saturation
        vecs.push_back(mk(1, 0, 4'b0000, 0, 0, 0,        0, 0, 0));
        vecs.push_back(mk(0, 0, 4'b0000, 1, 0, -3932160, 0, 0, 0));
        vecs.push_back(mk(0, 1, 4'b0001, 0, 0, 0, -3932160, 1, 0));
        vecs.push_back(mk(0, 1, 4'b0000, 0, 0, 0, -3686400, 1, 0));
        vecs.push_back(mk(0, 1, 4'b0001, 0, 0, 0, -6553600, 2, 1));
        // reset mid-integration with pre_spike[2] held through release
        vecs.push_back(mk(0, 1, 4'b0100, 0, 0, 0, -5488640, 3, 0));
        vecs.push_back(mk(1, 1, 4'b0100, 1, 0, 123,      0, 0, 0));
        vecs.push_back(mk(0, 1, 4'b0100, 0, 0, 0,        0, 0, 0));
        vecs.push_back(mk(0, 1, 4'b0101, 0, 0, 0,   655360, 1, 0));

        foreach (vecs[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            drive(vecs[i].rst, vecs[i].en, vecs[i].pre,
                  vecs[i].we, vecs[i].addr, vecs[i].wd);
            chk_cur(nm, vecs[i].cur);
            chk_cnt(nm, vecs[i].cnt);
            chk_sat(nm, vecs[i].sat);
        end

        // small positive current leaks one LSB per cycle down to zero
        drive(1, 0, 4'b0000, 0, 0, 0);
        drive(0, 0, 4'b0000, 1, 3, 15);
        drive(0, 1, 4'b1000, 0, 0, 0);
        chk_cur("leak_start", 15);
        for (int k = 14; k >= 0; k--) begin
            drive(0, 1, 4'b0000, 0, 0, 0);
            chk_cur($sformatf("leak_pos%0d", k), k);
        end
        drive(0, 1, 4'b0000, 0, 0, 0);
        chk_cur("leak_stay0", 0);

        // small negative current leaks up to zero
        drive(0, 0, 4'b0000, 1, 3, -3);
        drive(0, 1, 4'b1000, 0, 0, 0);
        chk_cur("leak_neg3", -3);
        drive(0, 1, 4'b0000, 0, 0, 0);
        chk_cur("leak_neg2", -2);
        drive(0, 1, 4'b0000, 0, 0, 0);
        chk_cur("leak_neg1", -1);
        drive(0, 1, 4'b0000, 0, 0, 0);
        chk_cur("leak_neg0", 0);

        // event counter saturates at 0xFFFF without wrapping
        drive(1, 0, 4'b0000, 0, 0, 0);
        for (int k = 0; k < 16384; k++) begin
            drive(0, 1, 4'b1111, 0, 0, 0);
            drive(0, 1, 4'b0000, 0, 0, 0);
        end
        chk_cnt("cnt_sat", 16'hFFFF);
        drive(0, 1, 4'b1111, 0, 0, 0);
        chk_cnt("cnt_hold", 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
